// File: rtl/uart_fifo_param.sv
// Parametrised circular-buffer FIFO for the UART TX/RX paths.
// First-word fall-through head, occupancy count, flush (explicit or on
// mode change), 16450 single-entry mode when en=0, and error pulses with
// sticky copies.
module uart_fifo_param #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  input  logic [CW-1:0]    threshold,
  output logic             thre_trigger,
  output logic             overrun,
  output logic             underrun,
  output logic             ovr_sticky,
  output logic             udr_sticky,
  input  logic             clr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          ovr_sticky_q, ovr_sticky_d;
  logic          udr_sticky_q, udr_sticky_d;

  logic [CW-1:0] eff_depth;
  logic          empty_int;
  logic          full_int;
  logic          flush_eff;
  logic          pop_ok;
  logic          push_ok;
  logic          mem_we;

  // Accept decisions and next-state computation, all from pre-edge state.
  always_comb begin
    eff_depth    = en ? CW'(DEPTH) : CW'(1);
    empty_int    = (count_q == '0);
    full_int     = (count_q == eff_depth);
    flush_eff    = flush || (en != en_q);
    pop_ok       = pop_in && !empty_int;
    push_ok      = push_in && (!full_int || pop_ok);
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    mem_we       = 1'b0;
    overrun_d    = 1'b0;
    underrun_d   = 1'b0;
    if (flush_eff) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      mem_we     = push_ok;
      overrun_d  = push_in && !push_ok;
      underrun_d = pop_in && !pop_ok;
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end
    if (overrun_d)    ovr_sticky_d = 1'b1;
    else if (clr_err) ovr_sticky_d = 1'b0;
    else              ovr_sticky_d = ovr_sticky_q;
    if (underrun_d)   udr_sticky_d = 1'b1;
    else if (clr_err) udr_sticky_d = 1'b0;
    else              udr_sticky_d = udr_sticky_q;
  end

  // Control state; en_q follows en through reset so releasing reset is not a mode change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      en_q         <= en;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      ovr_sticky_q <= 1'b0;
      udr_sticky_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      en_q         <= en;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      ovr_sticky_q <= ovr_sticky_d;
      udr_sticky_q <= udr_sticky_d;
    end
  end

  // Storage array, written only on an accepted push; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[wptr_q] <= din;
  end

  assign empty        = empty_int;
  assign full         = full_int;
  assign count        = count_q;
  assign dout         = empty_int ? '0 : mem_q[rptr_q];
  assign thre_trigger = (threshold != '0) && (count_q >= threshold);
  assign overrun      = overrun_q;
  assign underrun     = underrun_q;
  assign ovr_sticky   = ovr_sticky_q;
  assign udr_sticky   = udr_sticky_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed testbench for uart_fifo_param (WIDTH=8, DEPTH=16).
module tb_uart_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       flush;
  logic       push_in;
  logic       pop_in;
  logic [7:0] din;
  logic [7:0] dout;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic [4:0] threshold;
  logic       thre_trigger;
  logic       overrun;
  logic       underrun;
  logic       ovr_sticky;
  logic       udr_sticky;
  logic       clr_err;

  int checks_total  = 0;
  int checks_passed = 0;

  uart_fifo_param #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .push_in(push_in), .pop_in(pop_in), .din(din), .dout(dout),
    .count(count), .empty(empty), .full(full), .threshold(threshold),
    .thre_trigger(thre_trigger), .overrun(overrun), .underrun(underrun),
    .ovr_sticky(ovr_sticky), .udr_sticky(udr_sticky), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clear both sticky flags with no traffic.
  task automatic clear_sticky();
    push_in = 1'b0; pop_in = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; flush = 1'b0; push_in = 1'b1; pop_in = 1'b0;
    din = 8'h77; threshold = 5'd0; clr_err = 1'b0;
    repeat (3) step();
    checks_total++;
    if (count !== 5'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count);
    else checks_passed++;
    checks_total++;
    if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty);
    else checks_passed++;
    checks_total++;
    if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", dout);
    else checks_passed++;
    checks_total++;
    if (overrun !== 1'b0 || full !== 1'b0 || ovr_sticky !== 1'b0)
      $display("[TB] FAIL reset_flags: got ovr=%b full=%b sticky=%b expected 0 0 0",
               overrun, full, ovr_sticky);
    else checks_passed++;
    push_in = 1'b0;
    rst = 1'b1;
    step();
    checks_total++;
    if (count !== 5'd0) $display("[TB] FAIL reset_release_count: got %0d expected 0", count);
    else checks_passed++;
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 16; i++) begin
      push_in = 1'b1; din = 8'(i);
      step();
      checks_total++;
      if (count !== 5'(i)) $display("[TB] FAIL fill_count_%0d: got %0d expected %0d", i, count, i);
      else checks_passed++;
    end
    checks_total++;
    if (full !== 1'b1) $display("[TB] FAIL fill_full: got %b expected 1", full);
    else checks_passed++;
    din = 8'hAA;
    step();
    checks_total++;
    if (overrun !== 1'b1 || ovr_sticky !== 1'b1 || count !== 5'd16)
      $display("[TB] FAIL overrun_pulse: got ovr=%b sticky=%b count=%0d expected 1 1 16",
               overrun, ovr_sticky, count);
    else checks_passed++;
    push_in = 1'b0;
    step();
    checks_total++;
    if (overrun !== 1'b0 || ovr_sticky !== 1'b1)
      $display("[TB] FAIL overrun_one_cycle: got ovr=%b sticky=%b expected 0 1", overrun, ovr_sticky);
    else checks_passed++;
    for (int i = 1; i <= 16; i++) begin
      checks_total++;
      if (dout !== 8'(i)) $display("[TB] FAIL drain_dout_%0d: got %h expected %h", i, dout, 8'(i));
      else checks_passed++;
      pop_in = 1'b1;
      step();
    end
    pop_in = 1'b0;
    checks_total++;
    if (empty !== 1'b1 || dout !== 8'h00 || underrun !== 1'b0)
      $display("[TB] FAIL drain_empty: got empty=%b dout=%h udr=%b expected 1 00 0",
               empty, dout, underrun);
    else checks_passed++;
    clear_sticky();
    checks_total++;
    if (ovr_sticky !== 1'b0) $display("[TB] FAIL ovr_sticky_clear: got %b expected 0", ovr_sticky);
    else checks_passed++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 16; i++) begin
      push_in = 1'b1; din = 8'(i);
      step();
    end
    din = 8'h55; pop_in = 1'b1;
    step();
    push_in = 1'b0; pop_in = 1'b0;
    checks_total++;
    if (count !== 5'd16 || dout !== 8'h02 || overrun !== 1'b0)
      $display("[TB] FAIL full_push_pop: got count=%0d dout=%h ovr=%b expected 16 02 0",
               count, dout, overrun);
    else checks_passed++;
    for (int i = 2; i <= 17; i++) begin
      checks_total++;
      if (dout !== ((i == 17) ? 8'h55 : 8'(i)))
        $display("[TB] FAIL wrap_dout_%0d: got %h expected %h", i, dout,
                 (i == 17) ? 8'h55 : 8'(i));
      else checks_passed++;
      pop_in = 1'b1;
      step();
    end
    pop_in = 1'b0;
    checks_total++;
    if (empty !== 1'b1) $display("[TB] FAIL wrap_empty: got %b expected 1", empty);
    else checks_passed++;
  endtask

  task automatic test_threshold();
    threshold = 5'd10;
    for (int i = 0; i < 9; i++) begin
      push_in = 1'b1; din = 8'(8'h20 + i);
      step();
    end
    push_in = 1'b0;
    checks_total++;
    if (thre_trigger !== 1'b0) $display("[TB] FAIL thre_at_9: got %b expected 0", thre_trigger);
    else checks_passed++;
    push_in = 1'b1;
    step();
    push_in = 1'b0;
    checks_total++;
    if (thre_trigger !== 1'b1) $display("[TB] FAIL thre_at_10: got %b expected 1", thre_trigger);
    else checks_passed++;
    threshold = 5'd0;
    #1;
    checks_total++;
    if (thre_trigger !== 1'b0) $display("[TB] FAIL thre_zero: got %b expected 0", thre_trigger);
    else checks_passed++;
    threshold = 5'd10;
    pop_in = 1'b1;
    step();
    pop_in = 1'b0;
    checks_total++;
    if (thre_trigger !== 1'b0 || count !== 5'd9)
      $display("[TB] FAIL thre_after_pop: got thre=%b count=%0d expected 0 9", thre_trigger, count);
    else checks_passed++;
    flush = 1'b1; pop_in = 1'b1;
    step();
    flush = 1'b0; pop_in = 1'b0;
    checks_total++;
    if (count !== 5'd0 || underrun !== 1'b0)
      $display("[TB] FAIL flush_count: got count=%0d udr=%b expected 0 0", count, underrun);
    else checks_passed++;
    threshold = 5'd0;
  endtask

  task automatic test_underrun();
    pop_in = 1'b1;
    step();
    checks_total++;
    if (underrun !== 1'b1 || udr_sticky !== 1'b1)
      $display("[TB] FAIL underrun_first: got udr=%b sticky=%b expected 1 1", underrun, udr_sticky);
    else checks_passed++;
    step();
    pop_in = 1'b0;
    checks_total++;
    if (underrun !== 1'b1) $display("[TB] FAIL underrun_second: got %b expected 1", underrun);
    else checks_passed++;
    step();
    step();
    checks_total++;
    if (underrun !== 1'b0 || udr_sticky !== 1'b1)
      $display("[TB] FAIL udr_sticky_hold: got udr=%b sticky=%b expected 0 1", underrun, udr_sticky);
    else checks_passed++;
    pop_in = 1'b1; clr_err = 1'b1;
    step();
    pop_in = 1'b0; clr_err = 1'b0;
    checks_total++;
    if (udr_sticky !== 1'b1) $display("[TB] FAIL udr_set_wins: got %b expected 1", udr_sticky);
    else checks_passed++;
    clear_sticky();
    checks_total++;
    if (udr_sticky !== 1'b0) $display("[TB] FAIL udr_sticky_clear: got %b expected 0", udr_sticky);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    push_in = 1'b1; pop_in = 1'b1; din = 8'h9E;
    step();
    push_in = 1'b0; pop_in = 1'b0;
    checks_total++;
    if (count !== 5'd1 || dout !== 8'h9E || underrun !== 1'b1)
      $display("[TB] FAIL empty_push_pop: got count=%0d dout=%h udr=%b expected 1 9e 1",
               count, dout, underrun);
    else checks_passed++;
    pop_in = 1'b1;
    step();
    pop_in = 1'b0;
    checks_total++;
    if (empty !== 1'b1 || underrun !== 1'b0)
      $display("[TB] FAIL empty_push_pop_drain: got empty=%b udr=%b expected 1 0", empty, underrun);
    else checks_passed++;
    clear_sticky();
  endtask

  task automatic test_mode_change();
    for (int i = 0; i < 8; i++) begin
      push_in = 1'b1; din = 8'(8'h40 + i);
      step();
    end
    push_in = 1'b0;
    checks_total++;
    if (count !== 5'd8) $display("[TB] FAIL mode_prefill: got %0d expected 8", count);
    else checks_passed++;
    en = 1'b0;
    step();
    checks_total++;
    if (count !== 5'd0 || empty !== 1'b1)
      $display("[TB] FAIL mode_flush: got count=%0d empty=%b expected 0 1", count, empty);
    else checks_passed++;
    push_in = 1'b1; din = 8'h3C;
    step();
    checks_total++;
    if (full !== 1'b1 || count !== 5'd1 || dout !== 8'h3C)
      $display("[TB] FAIL single_full: got full=%b count=%0d dout=%h expected 1 1 3c",
               full, count, dout);
    else checks_passed++;
    din = 8'h3D;
    step();
    checks_total++;
    if (overrun !== 1'b1 || dout !== 8'h3C || ovr_sticky !== 1'b1)
      $display("[TB] FAIL single_overrun: got ovr=%b dout=%h sticky=%b expected 1 3c 1",
               overrun, dout, ovr_sticky);
    else checks_passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks_total++;
    if (count !== 5'd0 || overrun !== 1'b0 || ovr_sticky !== 1'b1)
      $display("[TB] FAIL flush_with_push: got count=%0d ovr=%b sticky=%b expected 0 0 1",
               count, overrun, ovr_sticky);
    else checks_passed++;
    en = 1'b1; din = 8'h99;
    step();
    checks_total++;
    if (count !== 5'd0) $display("[TB] FAIL mode_back_push_dropped: got %0d expected 0", count);
    else checks_passed++;
    step();
    push_in = 1'b0;
    checks_total++;
    if (count !== 5'd1 || dout !== 8'h99 || full !== 1'b0)
      $display("[TB] FAIL fifo_mode_resume: got count=%0d dout=%h full=%b expected 1 99 0",
               count, dout, full);
    else checks_passed++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_fill_overrun();
    test_full_push_pop();
    test_threshold();
    test_underrun();
    test_back_to_back();
    test_mode_change();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
